cover_toggle_drain: RTL and testbench



---
 rtl/cover_pkg.sv | 13 +
 rtl/cover_lsb_pick.sv | 24 ++
 rtl/cover_toggle_drain.sv | 115 +++++++++++
 tb/tb_cover_toggle_drain.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cover_pkg.sv
// Shared definitions for the coverage drain blocks: index width, the default
// design-wide point total and the report-slot state type.
package cover_pkg;

    localparam int COVER_IDX_W         = 64;
    localparam int COVER_TOTAL_DEFAULT = 8940;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_HOLD  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/cover_lsb_pick.sv
// Combinational lowest-set-bit finder: reports whether any bit is set, the
// isolated lowest bit as a one-hot mask, and its binary position.
module cover_lsb_pick #(
    parameter int WIDTH = 40,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic             any_o,
    output logic [WIDTH-1:0] onehot_o,
    output logic [IDX_W-1:0] idx_o
);

    // Two's-complement trick isolates the lowest set bit; the one-hot mask is
    // then OR-encoded so no priority chain is needed for the index.
    always_comb begin
        any_o    = |vec_i;
        onehot_o = vec_i & (~vec_i + WIDTH'(1));
        idx_o    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            idx_o = idx_o | (onehot_o[i] ? IDX_W'(i) : IDX_W'(0));
        end
    end

endmodule

// File: rtl/cover_toggle_drain.sv
// Collects toggle-coverage hits for one group of points and drains every newly
// covered point exactly once through a valid/ready report slot.
module cover_toggle_drain
    import cover_pkg::*;
#(
    parameter int          WIDTH       = 40,
    parameter int unsigned COVER_INDEX = 0,
    parameter int unsigned COVER_TOTAL = COVER_TOTAL_DEFAULT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           valid,
    input  logic                       clear,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [COVER_IDX_W-1:0]     out_index,
    output logic [$clog2(WIDTH+1)-1:0] covered_count,
    output logic                       all_covered
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (longint'(COVER_INDEX) + longint'(WIDTH) > longint'(COVER_TOTAL)) begin : g_range_err
        $error("cover_toggle_drain: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
    end

    slot_state_e                state_q, state_d;
    logic [WIDTH-1:0]           pending_q, pending_d;
    logic [WIDTH-1:0]           reported_q, reported_d;
    logic [COVER_IDX_W-1:0]     index_q, index_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       all_q, all_d;

    logic                       pick_any_s;
    logic [WIDTH-1:0]           pick_onehot_s;
    logic [IDX_W-1:0]           pick_idx_s;
    logic                       load_s;
    logic                       handshake_s;

    cover_lsb_pick #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_pick (
        .vec_i    (pending_q),
        .any_o    (pick_any_s),
        .onehot_o (pick_onehot_s),
        .idx_o    (pick_idx_s)
    );

    // Next-state for bitmaps, report slot and counters. The pick uses the
    // registered pending map, so a same-cycle hit waits one cycle.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        reported_d  = reported_q;
        index_d     = index_q;
        count_d     = count_q;
        handshake_s = (state_q == SLOT_HOLD) && out_ready;
        load_s      = (state_q == SLOT_EMPTY) || out_ready;

        if (clear) begin
            state_d    = SLOT_EMPTY;
            pending_d  = '0;
            reported_d = '0;
            count_d    = '0;
        end else begin
            pending_d = pending_q | (valid & ~reported_q);

            if (load_s && pick_any_s) begin
                pending_d  = pending_d & ~pick_onehot_s;
                reported_d = reported_q | pick_onehot_s;
                index_d    = COVER_IDX_W'(COVER_INDEX) + COVER_IDX_W'(pick_idx_s);
                state_d    = SLOT_HOLD;
            end else if (load_s) begin
                state_d = SLOT_EMPTY;
            end else begin
                state_d = state_q;
            end

            if (handshake_s && (count_q != CNT_W'(WIDTH))) begin
                count_d = count_q + CNT_W'(1);
            end else begin
                count_d = count_q;
            end
        end

        all_d = (count_d == CNT_W'(WIDTH));
    end

    // State registers; reset additionally returns the reported index to 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= SLOT_EMPTY;
            pending_q  <= '0;
            reported_q <= '0;
            index_q    <= '0;
            count_q    <= '0;
            all_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            reported_q <= reported_d;
            index_q    <= index_d;
            count_q    <= count_d;
            all_q      <= all_d;
        end
    end

    assign out_valid     = (state_q == SLOT_HOLD);
    assign out_index     = index_q;
    assign covered_count = count_q;
    assign all_covered   = all_q;

endmodule

// File: tb/tb_cover_toggle_drain.sv
// Bench for cover_toggle_drain: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_cover_toggle_drain;

    localparam int W    = 40;
    localparam int BASE = 100;

    logic          clock;
    logic          reset;
    logic [W-1:0]  valid;
    logic          clear;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_index;
    logic [5:0]    covered_count;
    logic          all_covered;

    int n_checks = 0;
    int n_pass   = 0;

    cover_toggle_drain #(
        .WIDTH       (W),
        .COVER_INDEX (BASE),
        .COVER_TOTAL (8940)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .valid         (valid),
        .clear         (clear),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_index     (out_index),
        .covered_count (covered_count),
        .all_covered   (all_covered)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model: sets of hit-but-unsent and already-sent points,
    // a single report slot and an acceptance counter.
    bit      m_pend[W];
    bit      m_rep[W];
    bit      m_vld;
    longint  m_idx;
    int      m_cnt;
    bit      m_started = 1'b0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    endtask

    task automatic model_step();
        bit p0[W];
        bit r0[W];
        int pick;
        if (reset) begin
            for (int i = 0; i < W; i++) begin m_pend[i] = 0; m_rep[i] = 0; end
            m_vld = 0; m_idx = 0; m_cnt = 0;
        end else if (clear) begin
            for (int i = 0; i < W; i++) begin m_pend[i] = 0; m_rep[i] = 0; end
            m_vld = 0; m_cnt = 0;
        end else begin
            p0 = m_pend;
            r0 = m_rep;
            if (m_vld && out_ready) m_cnt++;
            if (!m_vld || out_ready) begin
                pick = -1;
                for (int i = 0; i < W; i++) if (p0[i] && pick < 0) pick = i;
                if (pick >= 0) begin
                    m_vld = 1; m_idx = BASE + pick;
                    m_pend[pick] = 0; m_rep[pick] = 1;
                end else begin
                    m_vld = 0;
                end
            end
            for (int i = 0; i < W; i++)
                if (valid[i] && !p0[i] && !r0[i]) m_pend[i] = 1;
        end
        m_started = 1;
    endtask

    initial begin
        forever begin
            @(posedge clock);
            model_step();
        end
    end

    // Every-cycle comparison of DUT outputs against the model, away from the edge.
    always @(negedge clock) begin
        if (m_started) begin
            check("out_valid", out_valid, m_vld);
            check("out_index", out_index, m_idx);
            check("covered_count", covered_count, m_cnt);
            check("all_covered", all_covered, (m_cnt == W));
        end
    end

    task automatic tick(input logic [W-1:0] v, input logic c, input logic r);
        valid = v; clear = c; out_ready = r;
        @(negedge clock);
    endtask

    initial begin
        logic [W-1:0] rv;
        reset = 1'b1; valid = '1; clear = 1'b0; out_ready = 1'b0;

        // Reset held with every point hitting; nothing may survive it.
        repeat (3) tick('1, 1'b0, 1'b0);
        reset = 1'b0;
        tick('0, 1'b0, 1'b1);
        check("rst_valid", out_valid, 0);
        check("rst_count", covered_count, 0);
        check("rst_index", out_index, 0);
        repeat (3) tick('0, 1'b0, 1'b1);
        check("rst_nopend", out_valid, 0);

        // Single hit on bit 5: two-edge latency, one report, repeat hit dropped.
        tick(40'h20, 1'b0, 1'b1);
        check("b5_e0", out_valid, 0);
        tick('0, 1'b0, 1'b1);
        check("b5_valid", out_valid, 1);
        check("b5_index", out_index, 105);
        tick('0, 1'b0, 1'b1);
        check("b5_gone", out_valid, 0);
        check("b5_count", covered_count, 1);
        tick(40'h20, 1'b0, 1'b1);
        repeat (2) tick('0, 1'b0, 1'b1);
        check("b5_repeat", out_valid, 0);
        check("b5_count2", covered_count, 1);

        // Three points at once drain back-to-back in ascending order.
        tick('0, 1'b1, 1'b1);
        tick(40'h80_0000_0003, 1'b0, 1'b1);
        tick('0, 1'b0, 1'b1);
        check("tri_0", out_index, 100);
        tick('0, 1'b0, 1'b1);
        check("tri_1", out_index, 101);
        tick('0, 1'b0, 1'b1);
        check("tri_39", out_index, 139);
        check("tri_v", out_valid, 1);
        tick('0, 1'b0, 1'b1);
        check("tri_end", out_valid, 0);
        check("tri_count", covered_count, 3);

        // Backpressure holds the slot stable, then releases each point once.
        tick('0, 1'b1, 1'b1);
        tick(40'h84, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick('0, 1'b0, 1'b0);
            check("bp_hold", out_index, 102);
        end
        tick('0, 1'b0, 1'b1);
        check("bp_next", out_index, 107);
        check("bp_cnt1", covered_count, 1);
        tick('0, 1'b0, 1'b1);
        check("bp_end", out_valid, 0);
        check("bp_count", covered_count, 2);

        // All points continuously: 40 ascending reports, then all_covered.
        tick('0, 1'b1, 1'b1);
        tick('1, 1'b0, 1'b1);
        for (int k = 0; k < W; k++) begin
            tick('1, 1'b0, 1'b1);
            check("full_idx", out_index, BASE + k);
            check("full_cnt", covered_count, k);
        end
        check("full_not_yet", all_covered, 0);
        tick('1, 1'b0, 1'b1);
        check("full_count", covered_count, 40);
        check("full_all", all_covered, 1);
        check("full_empty", out_valid, 0);

        // Clear while holding 103 with ready high drops the report and a same-cycle hit.
        tick('0, 1'b1, 1'b1);
        tick(40'h8, 1'b0, 1'b0);
        tick('0, 1'b0, 1'b0);
        check("clr_hold", out_index, 103);
        tick(40'h200, 1'b1, 1'b1);
        check("clr_valid", out_valid, 0);
        check("clr_count", covered_count, 0);
        tick('0, 1'b0, 1'b1);
        tick('0, 1'b0, 1'b1);
        check("clr_no9", out_valid, 0);
        tick(40'h8, 1'b0, 1'b1);
        tick('0, 1'b0, 1'b1);
        check("clr_re3", out_index, 103);
        check("clr_re3v", out_valid, 1);
        tick('0, 1'b0, 1'b1);
        check("clr_re3c", covered_count, 1);

        // Randomized traffic with occasional clear and mid-run reset.
        for (int n = 0; n < 3000; n++) begin
            rv = W'({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
            if ($urandom_range(7) == 0) rv = '0;
            reset = ($urandom_range(299) == 0);
            tick(rv, ($urandom_range(127) == 0), ($urandom_range(3) != 0));
        end
        reset = 1'b0;
        repeat (50) tick('0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
